clk_div_bank: RTL and testbench
===============================

// Module: clk_div_bank
// PURPOSE
//  Synthesizable, parametrised successor to the bench-level fast/medium/slow clock toggles.
//  Generates NUM_CH divided clocks and single-cycle tick enables from one reference clock.
//  Each channel has a runtime-programmable divisor with glitch-free reload at terminal count.
//  Feeds timers, samplers and slow sub-blocks that must stay on the clk domain (tick) or need a slow square wave (div_clk_o).
// PARAMETERS
//  NUM_CH       3                 number of divider channels (1..16)
//  DIV_W        16                divisor width; legal divisor 1..2**DIV_W-1
//  DEFAULT_DIV  {500,50,1} packed reset divisor per channel, DIV_W bits each, ch0 in LSBs
// PORTS
//  clk        in   1              reference clock; all state on posedge
//  rst_n      in   1              asynchronous active-low reset
//  en_i       in   NUM_CH         per-channel run enable
//  cfg_we     in   1              divisor write strobe, single cycle
//  cfg_ch     in   $clog2(NUM_CH) target channel of write (min width 1)
//  cfg_div    in   DIV_W          new divisor value
//  cfg_err    out  1              registered 1-cycle pulse: write rejected
//  tick_o     out  NUM_CH         registered 1-cycle pulse per terminal count
//  div_clk_o  out  NUM_CH         registered square wave, period 2*D clk cycles
//  sync_start in   1              (only with CLK_DIV_BANK_SYNC_START_EN) realign all channels
// BEHAVIOUR
//  Reset: cnt=0, div_act=div_shd=DEFAULT_DIV[i], tick_o=0, div_clk_o=0, cfg_err=0.
//  Per channel, each posedge with en_i[i]=1:
//   cnt==0 -> tick_o<=1, div_clk_o<=~div_clk_o, cnt<=div_shd-1, div_act<=div_shd.
//   else   -> tick_o<=0, cnt<=cnt-1.
//  Result: tick every D cycles, div_clk_o toggles every D cycles (50% duty, period 2D).
//  D=1: tick_o held high while enabled; div_clk_o toggles every cycle.
//  First tick: appears after the first posedge sampling en_i[i]=1 (cnt idles at 0).
//  en_i[i]=0: cnt<=0, tick_o<=0, div_clk_o holds its level (no glitch, no forced low).
//  Config write: cfg_we=1, cfg_ch<NUM_CH, cfg_div!=0 -> div_shd[cfg_ch]<=cfg_div.
//   Channel enabled: takes effect at next terminal count; current period completes with old D.
//   Channel disabled: div_act also loaded same edge.
//   Write and terminal count on same edge: reload uses pre-edge div_shd; new value used next reload.
//  Rejected writes (cfg_div==0 or cfg_ch>=NUM_CH): no state change, cfg_err=1 next cycle.
//  Async reset mid-period: all outputs to reset values immediately; divisors revert to DEFAULT_DIV.
//  No combinational path from any input to any output.
// CONFIGURATION
//  CLK_DIV_BANK_SYNC_START_EN defined: sync_start port exists; sync_start=1 at posedge ->
//   all cnt<=0, all div_clk_o<=0, all tick_o<=0 (overrides normal update that cycle);
//   next edge, every enabled channel ticks together (phase-aligned; div_act loaded from div_shd).
//  Undefined: port absent; channels free-run, relative phase set only by en_i timing.
// STRUCTURE
//  clk_div_pkg: DIV_W default, MAX_CH=16, divisor typedef div_t, DEFAULT_DIV constant helpers.
//  Sub-module clk_div_chan: one channel (cnt, div_act, div_shd, tick, div_clk, sync input);
//   clk_div_bank = write decode, cfg_err register, generate loop of NUM_CH clk_div_chan.
// TESTING
//  Reset defaults, en_i=3'b111 for 1000 cycles -> ch0 2 ticks (period 500), ch1 20, ch2 1000; div_clk_o period 1000/100/2.
//  ch1 D=50, write D=10 mid-period at cnt=20 -> 20 more cycles to tick, then ticks every 10.
//  Write cfg_div=0 to ch0, then cfg_ch=3 -> cfg_err pulses twice, ch0 period stays 500.
//  ch2 disabled, D=7 written, enable -> first tick 1 cycle after enable, then every 7; disable -> div_clk_o level held.
//  rst_n low for 3 cycles mid-run at ch1 cnt=17 -> all outputs 0 immediately, divisors back to 500/50/1.
//  SYNC_START_EN: D=3,5,7 free-running, pulse sync_start -> all three tick on next edge, next coincident tick after 105 cycles.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div_bank divider bank.
// The optional realign port is enabled by CLK_DIV_BANK_SYNC_START_EN.
package clk_div_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int MAX_CH     = 16;
  localparam int NUM_CH_DEF = 3;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // ch0 sits in the LSBs: ch0=500, ch1=50, ch2=1
  localparam logic [NUM_CH_DEF*DIV_W_DEF-1:0] DEFAULT_DIV3 =
    {div_t'(1), div_t'(50), div_t'(500)};

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor configuration bus of clk_div_bank.
// Includes write strobe, target channel, value and reject pulse.
interface clk_div_bank_if #(
  parameter int DIV_W = 16,
  parameter int CH_W  = 2
);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_div,
    input  cfg_err
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_div,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: down counter, shadow/active divisor,
// registered tick pulse and square wave output.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEF_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             div_clk
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_shd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_act <= DEF_DIV;
      div_shd <= DEF_DIV;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end else begin
      if (wr) begin
        div_shd <= wr_div;
      end
      if (wr && !en) begin
        div_act <= wr_div;
      end
      if (sync) begin
        cnt     <= '0;
        tick    <= 1'b0;
        div_clk <= 1'b0;
      end else if (en) begin
        if (cnt == '0) begin
          tick    <= 1'b1;
          div_clk <= ~div_clk;
          cnt     <= div_shd - 1'b1;
          div_act <= div_shd;
        end else begin
          tick <= 1'b0;
          // clamp keeps cnt inside the running period
          if (cnt >= div_act) begin
            cnt <= div_act - 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end else begin
        cnt  <= '0;
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers with tick enables.
// Define CLK_DIV_BANK_SYNC_START_EN to add the sync_start realign port.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter logic [NUM_CH*DIV_W-1:0] DEFAULT_DIV = DEFAULT_DIV3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
`ifdef CLK_DIV_BANK_SYNC_START_EN
  input  logic              sync_start,
`endif
  clk_div_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] div_clk_o
);

  logic sync;
  logic cfg_ok;

`ifdef CLK_DIV_BANK_SYNC_START_EN
  assign sync = sync_start;
`else
  assign sync = 1'b0;
`endif

  assign cfg_ok = (cfg.cfg_div != '0) &&
                  (int'(cfg.cfg_ch) < NUM_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= cfg.cfg_we && !cfg_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;

    assign wr = cfg.cfg_we && cfg_ok &&
                (int'(cfg.cfg_ch) == i);

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEFAULT_DIV[i*DIV_W +: DIV_W])
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en_i[i]),
      .sync    (sync),
      .wr      (wr),
      .wr_div  (cfg.cfg_div),
      .tick    (tick_o[i]),
      .div_clk (div_clk_o[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank.
// Realign checks build only with CLK_DIV_BANK_SYNC_START_EN.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en;
  logic [2:0] tick;
  logic [2:0] dclk;
`ifdef CLK_DIV_BANK_SYNC_START_EN
  logic       sync_start;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_div_bank_if #(.DIV_W(16), .CH_W(2)) bus ();

  clk_div_bank #(
    .NUM_CH      (3),
    .DIV_W       (16),
    .DEFAULT_DIV (DEFAULT_DIV3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
`ifdef CLK_DIV_BANK_SYNC_START_EN
    .sync_start (sync_start),
`endif
    .cfg        (bus.slave),
    .tick_o     (tick),
    .div_clk_o  (dclk)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    en          = '0;
    bus.cfg_we  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_div = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wr(input int ch, input int d);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = ch[1:0];
    bus.cfg_div = d[15:0];
    step();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int lim, output int n);
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      step();
      if (tick[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc [3];
    int tg [3];
    int t0a, t0b, n;
    logic [2:0] prev;

`ifdef CLK_DIV_BANK_SYNC_START_EN
    sync_start = 1'b0;
`endif

    // reset defaults and free running
    do_reset();
    check("rst_tick", int'(tick), 0);
    check("rst_dclk", int'(dclk), 0);
    check("rst_err", int'(bus.cfg_err), 0);
    en   = 3'b111;
    prev = dclk;
    t0a  = -1;
    t0b  = -1;
    for (int c = 0; c < 3; c++) begin
      tc[c] = 0;
      tg[c] = 0;
    end
    for (int e = 1; e <= 1000; e++) begin
      step();
      for (int c = 0; c < 3; c++) begin
        if (tick[c]) tc[c]++;
        if (dclk[c] != prev[c]) tg[c]++;
      end
      if (tick[0]) begin
        if (t0a < 0) t0a = e;
        else if (t0b < 0) t0b = e;
      end
      prev = dclk;
    end
    check("ticks_ch0", tc[0], 2);
    check("ticks_ch1", tc[1], 20);
    check("ticks_ch2", tc[2], 1000);
    check("tgl_ch0", tg[0], 2);
    check("tgl_ch1", tg[1], 20);
    check("tgl_ch2", tg[2], 1000);
    check("ch0_first", t0a, 1);
    check("ch0_second", t0b, 501);
    check("dclk_end", int'(dclk), 0);

    // mid-period rewrite of ch1
    do_reset();
    en = 3'b010;
    repeat (30) step();
    wr(1, 10);
    check("wr_ok_err", int'(bus.cfg_err), 0);
    wait_tick(1, 100, n);
    check("ch1_old_tail", n, 20);
    wait_tick(1, 100, n);
    check("ch1_new_p1", n, 10);
    wait_tick(1, 100, n);
    check("ch1_new_p2", n, 10);

    // rejected writes
    do_reset();
    en = 3'b001;
    step();
    check("ch0_t1", int'(tick[0]), 1);
    wr(0, 0);
    check("err_zero", int'(bus.cfg_err), 1);
    wr(3, 7);
    check("err_ch3", int'(bus.cfg_err), 1);
    step();
    check("err_clr", int'(bus.cfg_err), 0);
    wait_tick(0, 600, n);
    check("ch0_keep", n, 497);
    wait_tick(0, 600, n);
    check("ch0_keep2", n, 500);

    // write while disabled, enable, disable
    do_reset();
    wr(2, 7);
    step();
    en = 3'b100;
    step();
    check("ch2_first", int'(tick[2]), 1);
    check("ch2_dclk1", int'(dclk[2]), 1);
    wait_tick(2, 50, n);
    check("ch2_p1", n, 7);
    check("ch2_dclk2", int'(dclk[2]), 0);
    wait_tick(2, 50, n);
    check("ch2_p2", n, 7);
    en = 3'b000;
    repeat (3) step();
    check("ch2_hold", int'(dclk[2]), 1);
    check("ch2_notick", int'(tick[2]), 0);

    // async reset mid-run
    do_reset();
    wr(0, 20);
    en = 3'b111;
    repeat (33) step();
    check("pre_dclk1", int'(dclk[1]), 1);
    rst_n = 1'b0;
    #1;
    check("arst_tick", int'(tick), 0);
    check("arst_dclk", int'(dclk), 0);
    repeat (3) @(posedge clk);
    #1;
    check("arst_hold", int'(tick | dclk), 0);
    rst_n = 1'b1;
    wait_tick(1, 100, n);
    check("post_ch1_t", n, 1);
    wait_tick(1, 100, n);
    check("post_ch1_p", n, 50);
    wait_tick(0, 600, n);
    check("post_ch0_p", n, 450);

`ifdef CLK_DIV_BANK_SYNC_START_EN
    do_reset();
    wr(0, 3);
    wr(1, 5);
    wr(2, 7);
    en = 3'b111;
    repeat (11) step();
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    check("sync_tick0", int'(tick), 0);
    check("sync_dclk0", int'(dclk), 0);
    step();
    check("sync_all", int'(tick), 7);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (tick == 3'b111) begin
        n = k;
        break;
      end
    end
    check("sync_lcm", n, 105);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
